usb_config_loader: RTL and testbench

Configuration controller for `universal_switch_box`. It accepts a configuration stream as DW-bit words over a valid/ready handshake and assembles the words into a shadow register. It then commits the full CW-bit vector to the switch box `c` bus in a single cycle, so the routing fabric never sees a partially written configuration. It sits between the fabric's configuration port, a host or scan bridge, and one switch box instance.

---
 rtl/usb_config_loader.sv | 152 +++++++++++++++
 tb/tb_usb_config_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb_config_loader.sv
// Configuration loader for universal_switch_box: assembles DW-bit words into a shadow register and commits all CW bits at once.
// Optional macro USB_CFG_CHECK_EN adds a trailing XOR check word before the commit.
module usb_config_loader #(
  parameter  int WS   = 7,
  parameter  int WD   = 6,
  parameter  int DW   = 8,
  localparam int CW   = WS * 6 + WD / 2 * 6,
  localparam int NW   = (CW + DW - 1) / DW,
  localparam int CNTW = $clog2(NW + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          clear,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [DW-1:0] cfg_data,
  output logic [CW-1:0] c,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    CHECK  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  localparam logic [CW-1:0] WORD_MASK = CW'({DW{1'b1}});

  state_t          state, state_n;
  logic [CNTW-1:0] cnt;
  logic [CW-1:0]   shadow;
  logic [31:0]     sh;
  logic            hs;
  logic            shadow_clr;
  logic            wr;
  logic            c_load;
  logic            c_clr;
  logic            done_n;
  logic            err_n;

`ifdef USB_CFG_CHECK_EN
  logic [DW-1:0]   acc;
`endif

  assign hs = cfg_valid && cfg_ready;
  assign sh = 32'(cnt) * 32'(DW);

  always_comb begin
    state_n    = state;
    shadow_clr = 1'b0;
    wr         = 1'b0;
    c_load     = 1'b0;
    c_clr      = 1'b0;
    done_n     = 1'b0;
    err_n      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n    = LOAD;
          shadow_clr = 1'b1;
        end else if (clear) begin
          c_clr  = 1'b1;
          done_n = 1'b1;
        end
      end
      LOAD: begin
        if (hs) begin
          wr = 1'b1;
          if (cnt == CNTW'(NW - 1)) begin
`ifdef USB_CFG_CHECK_EN
            state_n = CHECK;
`else
            state_n = COMMIT;
`endif
          end
        end
      end
`ifdef USB_CFG_CHECK_EN
      CHECK: begin
        if (hs) begin
          if (cfg_data == acc) begin
            state_n = COMMIT;
          end else begin
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end
      end
`endif
      COMMIT: begin
        c_load  = 1'b1;
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they track the state exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      shadow    <= '0;
      c         <= '0;
      busy      <= 1'b0;
      cfg_ready <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      busy      <= (state_n != IDLE);
      cfg_ready <= (state_n == LOAD) || (state_n == CHECK);
      done      <= done_n;
      if (shadow_clr) begin
        cnt    <= '0;
        shadow <= '0;
      end else if (wr) begin
        cnt    <= cnt + 1'b1;
        // Shifting within CW bits drops the part of the last word beyond CW-1.
        shadow <= (shadow & ~(WORD_MASK << sh)) | (CW'(cfg_data) << sh);
      end
      if (c_load) begin
        c <= shadow;
      end else if (c_clr) begin
        c <= '0;
      end
    end
  end

`ifdef USB_CFG_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      err <= 1'b0;
    end else begin
      err <= err_n;
      if (shadow_clr) begin
        acc <= '0;
      end else if (wr) begin
        acc <= acc ^ cfg_data;
      end
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_usb_config_loader.sv
// Randomized self-checking bench for usb_config_loader against a word-list reference model.
// Compile with +define+USB_CFG_CHECK_EN to exercise the check-word variant.
module tb_usb_config_loader;

  localparam int DW = 8;
  localparam int CW = 60;
  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [DW-1:0] cfg_data = '0;
  logic [CW-1:0] c;
  logic          busy;
  logic          done;
  logic          err;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] words [NW];
  logic [DW-1:0] chkword;
  logic [CW-1:0] exp_c = '0;

  usb_config_loader #(.WS(7), .WD(6), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .c(c), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: word i occupies bits i*DW upward; anything past CW-1 is dropped.
  function automatic logic [CW-1:0] model_c();
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < NW; i++) r = r | (128'(words[i]) << (i * DW));
    return r[CW-1:0];
  endfunction

  function automatic logic [DW-1:0] model_acc();
    logic [DW-1:0] a;
    a = '0;
    for (int i = 0; i < NW; i++) a = a ^ words[i];
    return a;
  endfunction

  // mode: 0 = valid held high, 1 = valid every other cycle, 2 = random stalls
  task automatic do_load(input int mode, input bit poke, input bit with_clear);
    logic [CW-1:0] old_c;
    int total, idx, guard, steps;
    bit v, good;
    old_c = c;
`ifdef USB_CFG_CHECK_EN
    total = NW + 1;
    good  = (chkword == model_acc());
`else
    total = NW;
    good  = 1'b1;
`endif
    start = 1'b1;
    clear = with_clear;
    step();
    start = 1'b0;
    clear = 1'b0;
    steps = 1;
    chk("start_busy", busy, 1);
    chk("start_c", c, old_c);
    chk("start_done", done, 0);
    idx = 0;
    guard = 0;
    while (idx < total && guard < 400) begin
      chk("load_ready", cfg_ready, 1);
      chk("load_c_hold", c, old_c);
      chk("load_done", done, 0);
      case (mode)
        0: v = 1'b1;
        1: v = (guard % 2) == 1;
        default: v = ($urandom % 100) >= 40;
      endcase
      cfg_valid = v;
      cfg_data  = v ? ((idx < NW) ? words[idx] : chkword) : DW'($urandom);
      if (poke) begin
        start = ($urandom % 3) == 0;
        clear = ($urandom % 3) == 0;
      end
      step();
      steps++;
      guard++;
      if (v) idx++;
    end
    cfg_valid = 1'b0;
    start = 1'b0;
    clear = 1'b0;
    if (guard >= 400) chk("load_timeout", 1, 0);
    if (good) begin
      chk("commit_ready", cfg_ready, 0);
      chk("commit_busy", busy, 1);
      chk("commit_c_hold", c, old_c);
      step();
      steps++;
      exp_c = model_c();
      chk("done_pulse", done, 1);
      chk("done_busy", busy, 0);
      chk("commit_c", c, exp_c);
      chk("commit_err", err, 0);
      if (mode == 0) chk("latency", steps, total + 2);
    end else begin
      chk("err_pulse", err, 1);
      chk("err_done", done, 0);
      chk("err_busy", busy, 0);
      chk("err_c", c, old_c);
    end
    step();
    chk("done_drop", done, 0);
    chk("err_drop", err, 0);
    chk("idle_c", c, exp_c);
  endtask

  task automatic abort_load(input int n);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = DW'($urandom);
      step();
    end
    cfg_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_c = '0;
    chk("abort_c", c, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", cfg_ready, 0);
    chk("abort_done", done, 0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    exp_c = '0;
    chk("clear_c", c, 0);
    chk("clear_done", done, 1);
    chk("clear_busy", busy, 0);
    step();
    chk("clear_done_drop", done, 0);
  endtask

  task automatic fill_seq();
    for (int i = 0; i < NW; i++) words[i] = DW'(i + 1);
    chkword = model_acc();
  endtask

  initial begin
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_c", c, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cfg_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);

    fill_seq();
    do_load(0, 1'b0, 1'b0);
    chk("dir_c", c, 64'h0807060504030201);

    do_clear();
    do_load(1, 1'b1, 1'b0);
    chk("stall_c", c, 64'h0807060504030201);

    fill_seq();
    do_load(2, 1'b0, 1'b1);
    chk("start_clear_c", c, 64'h0807060504030201);

    abort_load(4);
    for (int i = 0; i < NW; i++) words[i] = 8'hFF;
    chkword = model_acc();
    do_load(0, 1'b0, 1'b0);
    chk("ones_c", c, {4'h0, {CW{1'b1}}});

    do_clear();

`ifdef USB_CFG_CHECK_EN
    fill_seq();
    do_load(0, 1'b0, 1'b0);
    chk("chk_good_c", c, 64'h0807060504030201);
    chkword = 8'h00;
    do_load(0, 1'b0, 1'b0);
    chk("chk_bad_c", c, 64'h0807060504030201);
`endif

    for (int it = 0; it < 40; it++) begin
      int op;
      op = $urandom % 6;
      for (int i = 0; i < NW; i++) words[i] = DW'($urandom);
      chkword = (($urandom % 4) == 0) ? DW'($urandom) : model_acc();
      if (op == 0) do_clear();
      else if (op == 1) abort_load($urandom % NW);
      else do_load($urandom % 3, ($urandom % 2) == 1, ($urandom % 4) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
